// File: rtl/tinyalu_issuer.sv
// rtl/tinyalu_issuer.sv - command FIFO and start-hold sequencer in front of the tinyalu datapath
// Optional: TINYALU_ISSUER_DONE_CHECK_EN makes err latch when alu_done is low at capture.
module tinyalu_issuer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [7:0]  cmd_a_i,
  input  logic [7:0]  cmd_b_i,
  output logic        alu_start_o,
  output logic [2:0]  alu_op_o,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  input  logic        alu_done_i,
  input  logic [15:0] alu_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [2:0]  rsp_op_o,
  output logic [15:0] rsp_result_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  state_t        state_q;
  logic [1:0]    run_cnt_q;
  logic          alu_start_q;
  logic [2:0]    alu_op_q;
  logic [7:0]    alu_a_q, alu_b_q;
  logic          rsp_valid_q;
  logic [2:0]    rsp_op_q;
  logic [15:0]   rsp_result_q;

  logic          full, empty, push, pop;
  logic [18:0]   head;
  logic [2:0]    head_op;
  logic [7:0]    head_a, head_b;
  logic          head_is_alu;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  // Ready is gated by reset_n so nothing is offered while the block is held in reset.
  assign cmd_ready_o = reset_n && !full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == IDLE) && !empty;

  assign head        = mem_q[rd_ptr_q];
  assign head_op     = head[18:16];
  assign head_a      = head[15:8];
  assign head_b      = head[7:0];
  assign head_is_alu = (head_op >= 3'd1) && (head_op <= 3'd4);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op_i, cmd_a_i, cmd_b_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ALU pins only change on a pop so the result mux stays stable through capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      run_cnt_q    <= 2'd0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= 3'd0;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 3'd0;
      rsp_result_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            rsp_op_q <= head_op;
            if (head_is_alu) begin
              alu_op_q    <= head_op;
              alu_a_q     <= head_a;
              alu_b_q     <= head_b;
              alu_start_q <= 1'b1;
              run_cnt_q   <= (head_op == 3'd4) ? 2'd3 : 2'd1;
              state_q     <= RUN;
            end else begin
              rsp_result_q <= 16'd0;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        RUN: begin
          run_cnt_q <= run_cnt_q - 2'd1;
          if (run_cnt_q == 2'd1) begin
            alu_start_q <= 1'b0;
            state_q     <= CAPT;
          end
        end
        CAPT: begin
          // add/and/xor only produce a meaningful low byte.
          rsp_result_q <= (alu_op_q == 3'd4) ? alu_result_i : {8'h00, alu_result_i[7:0]};
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TINYALU_ISSUER_DONE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((state_q == CAPT) && !alu_done_i) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_alu_done;

  assign unused_alu_done = alu_done_i;
  assign err_o           = 1'b0;
`endif

  assign alu_start_o  = alu_start_q;
  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_op_o     = rsp_op_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_tinyalu_issuer.sv
// tb/tb_tinyalu_issuer.sv - randomized and directed bench for tinyalu_issuer with a scoreboard reference
module tb_tinyalu_issuer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_op;
  logic [15:0] rsp_result;
  logic        busy, err;

  always #5 clk = ~clk;

  tinyalu_issuer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .alu_start_o  (alu_start),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_done_i   (alu_done),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_op_o     (rsp_op),
    .rsp_result_o (rsp_result),
    .busy_o       (busy),
    .err_o        (err)
  );

  // ALU stand-in: upper result bits of add/and/xor carry junk the issuer must mask.
  logic prev_start = 1'b0;
  logic hold_done_low = 1'b0;

  always @(posedge clk) prev_start <= alu_start;
  assign alu_done = !hold_done_low && prev_start && !alu_start;

  always_comb begin
    case (alu_op)
      3'd1:    alu_result = 16'(alu_a) + 16'(alu_b);
      3'd2:    alu_result = {~alu_a, alu_a & alu_b};
      3'd3:    alu_result = {~alu_b, alu_a ^ alu_b};
      3'd4:    alu_result = 16'(alu_a) * 16'(alu_b);
      default: alu_result = 16'hDEAD;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   rsp_cyc_q[$];
  int   n_vec = 0;
  int   n_miscomp = 0;
  int   n_rsp = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input int op, input int a, input int b);
    case (op)
      1:       return 16'((a + b) % 256);
      2:       return 16'(a & b);
      3:       return 16'(a ^ b);
      4:       return 16'(a * b);
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic        prev_hold = 1'b0;
  logic [2:0]  held_op;
  logic [15:0] held_res;
  int          run_len = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      run_len   = 0;
      prev_hold = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        sb_e.op  = cmd_op;
        sb_e.res = ref_result(int'(cmd_op), int'(cmd_a), int'(cmd_b));
        sb_q.push_back(sb_e);
      end
      if (prev_hold) begin
        check_eq("rsp_hold_valid", rsp_valid, 1);
        check_eq("rsp_hold_op", rsp_op, held_op);
        check_eq("rsp_hold_result", rsp_result, held_res);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          sb_e = sb_q.pop_front();
          check_eq("rsp_op", rsp_op, sb_e.op);
          check_eq("rsp_result", rsp_result, sb_e.res);
        end
        n_rsp++;
        rsp_cyc_q.push_back(cyc);
      end
      prev_hold = rsp_valid && !rsp_ready;
      held_op   = rsp_op;
      held_res  = rsp_result;
      if (alu_start) begin
        run_len++;
      end else if (run_len > 0) begin
        check_eq("start_len", run_len, (alu_op == 3'd4) ? 3 : 1);
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_alu_start"}, alu_start, 0);
    check_eq({tag, "_alu_op"}, alu_op, 0);
    check_eq({tag, "_alu_a"}, alu_a, 0);
    check_eq({tag, "_alu_b"}, alu_b, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_op"}, rsp_op, 0);
    check_eq({tag, "_rsp_result"}, rsp_result, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_zero("rst");
    sb_q.delete();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_ready", cmd_ready, 1);
    check_eq("rst_release_busy", busy, 0);
    tick();
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ok;
    ok        = 0;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accept", ok, 1);
  endtask

  task automatic single(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input int exp_starts);
    int lat, starts;
    rsp_ready = 1'b1;
    send(op, a, b);
    lat    = 0;
    starts = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (alu_start) starts++;
      if (rsp_valid) lat = k;
      if (op == 3'd4 && k == 5) check_eq("mul_op_in_capt", alu_op, 4);
      tick();
    end
    check_eq("latency", lat, exp_lat);
    check_eq("start_cycles", starts, exp_starts);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (sb_q.size() != 0 || busy); i++) tick();
    check_eq("drain_empty", sb_q.size(), 0);
    check_eq("drain_idle", busy, 0);
  endtask

  int base_rsp;
  int rsp_seen;
  logic stim_done;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    rsp_ready = 1'b0;
    stim_done = 1'b0;
    do_reset();

    single(3'd1, 8'hFF, 8'h02, 4, 1);
    single(3'd4, 8'hFF, 8'hFF, 6, 3);
    single(3'd0, 8'($urandom), 8'($urandom), 2, 0);
    single(3'd7, 8'($urandom), 8'($urandom), 2, 0);
    single(3'd2, 8'hC3, 8'h5A, 4, 1);

    // Fill the FIFO behind a stalled response.
    rsp_ready = 1'b0;
    base_rsp  = n_rsp;
    for (int i = 0; i <= DEPTH; i++) send(3'd3, 8'hA5, 8'(8'h0F + i));
    tick();
    tick();
    @(negedge clk);
    check_eq("full_ready_low", cmd_ready, 0);
    check_eq("full_busy", busy, 1);
    check_eq("full_rsp_result", rsp_result, 16'h00AA);
    tick();
    cmd_op    = 3'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_no_push", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check_eq("full_rsp_count", n_rsp - base_rsp, DEPTH + 1);

    // Back-to-back throughput.
    rsp_cyc_q.delete();
    for (int i = 0; i < 3; i++) send(3'd3, 8'(i), 8'h33);
    drain();
    check_eq("tput_xor", rsp_cyc_q[2] - rsp_cyc_q[1], 4);
    rsp_cyc_q.delete();
    for (int i = 0; i < 2; i++) send(3'd4, 8'(i + 7), 8'h11);
    drain();
    check_eq("tput_mul", rsp_cyc_q[1] - rsp_cyc_q[0], 6);

    // Reset in the second RUN cycle of a mul, with another command queued.
    send(3'd4, 8'h12, 8'h34);
    send(3'd1, 8'h01, 8'h02);
    @(negedge clk);
    check_eq("mid_rst_start_seen", alu_start, 1);
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check_zero("mid_rst");
    tick();
    sb_q.delete();
    reset_n  = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || busy || alu_start) rsp_seen++;
      tick();
    end
    check_eq("mid_rst_quiet", rsp_seen, 0);

    // Randomized traffic with random response back-pressure.
    base_rsp = n_rsp;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        stim_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !stim_done; c++) begin
          tick();
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    check_eq("rand_rsp_count", n_rsp - base_rsp, 60);

    // Done check: ALU never raises done.
    @(negedge clk);
    check_eq("err_before", err, 0);
    tick();
    hold_done_low = 1'b1;
    single(3'd1, 8'h10, 8'h20, 4, 1);
    @(negedge clk);
`ifdef TINYALU_ISSUER_DONE_CHECK_EN
    check_eq("err_set", err, 1);
`else
    check_eq("err_tied_low", err, 0);
`endif
    tick();
    hold_done_low = 1'b0;
    single(3'd2, 8'hF0, 8'h3C, 4, 1);
    @(negedge clk);
`ifdef TINYALU_ISSUER_DONE_CHECK_EN
    check_eq("err_sticky", err, 1);
`else
    check_eq("err_still_low", err, 0);
`endif
    tick();
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
